gain_ramp_processor: RTL and testbench

//  Audio-path sample processor between the ADC interface and the DAC driver.
//  - Removes the ADC offset and applies a programmable integer gain with saturation.
//  - Re-applies the DAC offset and outputs one sample per input strobe.
//  - Gain changes ramp by +/-1 per processed sample, so switching gain causes no clicks.
//  - Saturation events raise a sticky clip flag and increment a saturating counter.

---
 rtl/gain_ramp_processor.sv | 132 +++++++++++++
 tb/tb_gain_ramp_processor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_ramp_processor.sv
// Two-stage ADC-to-DAC sample path: offset removal, saturating gain,
// click-free gain ramping and clip statistics.
module gain_ramp_processor #(
    parameter int                 DATA_W     = 10,
    parameter int                 GAIN_W     = 4,
    parameter logic [DATA_W-1:0]  ADC_OFFSET = 10'h181,
    parameter logic [DATA_W-1:0]  DAC_OFFSET = 10'h200,
    parameter logic [GAIN_W-1:0]  RESET_GAIN = GAIN_W'(1),
    parameter int                 CNT_W      = 8
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [GAIN_W-1:0] gain_target,
    input  logic              clip_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [GAIN_W-1:0] gain_cur,
    output logic              ramping,
    output logic              clip,
    output logic [CNT_W-1:0]  clip_count
);

    localparam int P_W = DATA_W + GAIN_W + 1;
    localparam logic signed [P_W-1:0] P_MAX = P_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [P_W-1:0] P_MIN = -P_MAX - P_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;

    logic [DATA_W-1:0] r_x;
    logic              r_v1;
    logic [DATA_W-1:0] r_out;
    logic              r_out_v;
    logic [GAIN_W-1:0] r_gain;
    logic [1:0]        r_state;
    logic              r_clip;
    logic [CNT_W-1:0]  r_cnt;

    logic signed [P_W-1:0] w_p;
    logic [DATA_W-1:0]     w_y;
    logic                  w_clamp;
    logic                  w_clip_evt;
    logic                  w_step_up;
    logic                  w_step_dn;
    logic [GAIN_W-1:0]     w_gain_nxt;
    logic [1:0]            w_state_nxt;

    assign w_p = $signed(r_x) * $signed({1'b0, r_gain});

    always_comb begin
        w_y     = w_p[DATA_W-1:0];
        w_clamp = 1'b0;
        if (w_p > P_MAX) begin
            w_y     = P_MAX[DATA_W-1:0];
            w_clamp = 1'b1;
        end else if (w_p < P_MIN) begin
            w_y     = P_MIN[DATA_W-1:0];
            w_clamp = 1'b1;
        end
    end

    assign w_clip_evt = r_v1 && w_clamp;

    // The target compare keeps a stale ramp direction from overshooting or wrapping.
    assign w_step_up = r_v1 && (r_state == S_UP) && (r_gain < gain_target);
    assign w_step_dn = r_v1 && (r_state == S_DOWN) && (r_gain > gain_target);

    always_comb begin
        w_gain_nxt = r_gain;
        if (w_step_up)
            w_gain_nxt = r_gain + GAIN_W'(1);
        else if (w_step_dn)
            w_gain_nxt = r_gain - GAIN_W'(1);
    end

    // Next state looks at the post-step gain so arrival returns to IDLE at once.
    always_comb begin
        w_state_nxt = S_IDLE;
        unique case (1'b1)
            (gain_target > w_gain_nxt): w_state_nxt = S_UP;
            (gain_target < w_gain_nxt): w_state_nxt = S_DOWN;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_v1    <= 1'b0;
            r_out   <= DAC_OFFSET;
            r_out_v <= 1'b0;
            r_gain  <= RESET_GAIN;
            r_state <= S_IDLE;
        end else begin
            r_v1    <= data_valid;
            r_out_v <= r_v1;
            r_gain  <= w_gain_nxt;
            r_state <= w_state_nxt;
            if (data_valid)
                r_x <= data_in - ADC_OFFSET;
            if (r_v1)
                r_out <= w_y + DAC_OFFSET;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip <= 1'b0;
            r_cnt  <= '0;
        end else if (w_clip_evt) begin
            r_clip <= 1'b1;
            if (clip_clr)
                r_cnt <= CNT_W'(1);
            else if (!(&r_cnt))
                r_cnt <= r_cnt + CNT_W'(1);
        end else if (clip_clr) begin
            r_clip <= 1'b0;
            r_cnt  <= '0;
        end
    end

    assign data_out   = r_out;
    assign out_valid  = r_out_v;
    assign gain_cur   = r_gain;
    assign ramping    = (r_state != S_IDLE);
    assign clip       = r_clip;
    assign clip_count = r_cnt;

endmodule

// File: tb/tb_gain_ramp_processor.sv
// Directed bench for gain_ramp_processor: offset/gain path, ramping,
// saturation, clip statistics, streaming and reset behaviour.
module tb_gain_ramp_processor;

    logic       sysclk;
    logic       rst_n;
    logic       data_valid;
    logic [9:0] data_in;
    logic [3:0] gain_target;
    logic       clip_clr;
    logic [9:0] data_out;
    logic       out_valid;
    logic [3:0] gain_cur;
    logic       ramping;
    logic       clip;
    logic [7:0] clip_count;

    int errors = 0;
    int checks = 0;

    gain_ramp_processor dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .gain_target (gain_target),
        .clip_clr    (clip_clr),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .gain_cur    (gain_cur),
        .ramping     (ramping),
        .clip        (clip),
        .clip_count  (clip_count)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic send(input logic [9:0] d);
        data_in    = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic ramp_to(input logic [3:0] t, input int n);
        gain_target = t;
        tick();
        repeat (n) begin
            send(10'h181);
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        data_valid  = 1'b0;
        data_in     = '0;
        gain_target = 4'd1;
        clip_clr    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (data_out !== 10'h200) begin
            errors++; $display("FAIL rst_data_out got=%h exp=200", data_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (gain_cur !== 4'd1) begin
            errors++; $display("FAIL rst_gain got=%0d exp=1", gain_cur);
        end
        checks++;
        if ({ramping, clip, clip_count} !== 10'd0) begin
            errors++;
            $display("FAIL rst_flags got=%b%b%0d exp=000", ramping, clip, clip_count);
        end
    endtask

    task automatic test_pass();
        ramp_to(4'd4, 3);
        checks++;
        if (gain_cur !== 4'd4 || ramping !== 1'b0) begin
            errors++; $display("FAIL pass_gain got=%0d/%b exp=4/0", gain_cur, ramping);
        end
        send(10'h18B);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL pass_lat1 got=%b exp=0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || data_out !== 10'h228) begin
            errors++;
            $display("FAIL pass_out got=%b/%h exp=1/228", out_valid, data_out);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || data_out !== 10'h228) begin
            errors++;
            $display("FAIL pass_hold got=%b/%h exp=0/228", out_valid, data_out);
        end
    endtask

    task automatic test_ramp();
        logic [9:0] e [4];
        e = '{10'h228, 10'h232, 10'h23C, 10'h246};
        gain_target = 4'd7;
        checks++;
        if (ramping !== 1'b0) begin
            errors++; $display("FAIL ramp_pre got=%b exp=0", ramping);
        end
        tick();
        checks++;
        if (ramping !== 1'b1) begin
            errors++; $display("FAIL ramp_start got=%b exp=1", ramping);
        end
        for (int i = 0; i < 4; i++) begin
            send(10'h18B);
            tick();
            checks++;
            if (out_valid !== 1'b1 || data_out !== e[i]) begin
                errors++;
                $display("FAIL ramp_out%0d got=%b/%h exp=1/%h", i, out_valid, data_out, e[i]);
            end
            checks++;
            if (ramping !== (i < 2)) begin
                errors++; $display("FAIL ramp_flag%0d got=%b exp=%b", i, ramping, i < 2);
            end
        end
        checks++;
        if (gain_cur !== 4'd7) begin
            errors++; $display("FAIL ramp_gain got=%0d exp=7", gain_cur);
        end
    endtask

    task automatic test_saturate();
        ramp_to(4'd4, 3);
        send(10'h249);
        tick();
        checks++;
        if (data_out !== 10'h3FF || clip !== 1'b1 || clip_count !== 8'd1) begin
            errors++;
            $display("FAIL sat_hi got=%h/%b/%0d exp=3ff/1/1", data_out, clip, clip_count);
        end
        send(10'h0B9);
        tick();
        checks++;
        if (data_out !== 10'h000 || clip !== 1'b1 || clip_count !== 8'd2) begin
            errors++;
            $display("FAIL sat_lo got=%h/%b/%0d exp=000/1/2", data_out, clip, clip_count);
        end
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
        checks++;
        if (clip !== 1'b0 || clip_count !== 8'd0) begin
            errors++; $display("FAIL sat_clr got=%b/%0d exp=0/0", clip, clip_count);
        end
        send(10'h249);
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
        checks++;
        if (clip !== 1'b1 || clip_count !== 8'd1) begin
            errors++; $display("FAIL sat_clr_evt got=%b/%0d exp=1/1", clip, clip_count);
        end
        repeat (260) begin
            send(10'h249);
            tick();
        end
        checks++;
        if (clip !== 1'b1 || clip_count !== 8'd255) begin
            errors++; $display("FAIL sat_cnt_max got=%b/%0d exp=1/255", clip, clip_count);
        end
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
    endtask

    task automatic test_gain0();
        ramp_to(4'd0, 4);
        checks++;
        if (gain_cur !== 4'd0) begin
            errors++; $display("FAIL g0_gain got=%0d exp=0", gain_cur);
        end
        send(10'h249);
        tick();
        checks++;
        if (data_out !== 10'h200 || clip !== 1'b0) begin
            errors++; $display("FAIL g0_pos got=%h/%b exp=200/0", data_out, clip);
        end
        send(10'h0B9);
        tick();
        checks++;
        if (data_out !== 10'h200 || clip !== 1'b0) begin
            errors++; $display("FAIL g0_neg got=%h/%b exp=200/0", data_out, clip);
        end
    endtask

    task automatic test_retarget();
        logic [9:0] e [4];
        e = '{10'h23C, 10'h232, 10'h228, 10'h21E};
        ramp_to(4'd4, 4);
        gain_target = 4'd12;
        tick();
        send(10'h18B);
        tick();
        send(10'h18B);
        tick();
        checks++;
        if (data_out !== 10'h232 || gain_cur !== 4'd6) begin
            errors++; $display("FAIL rt_up got=%h/%0d exp=232/6", data_out, gain_cur);
        end
        gain_target = 4'd2;
        tick();
        checks++;
        if (ramping !== 1'b1 || gain_cur !== 4'd6) begin
            errors++; $display("FAIL rt_turn got=%b/%0d exp=1/6", ramping, gain_cur);
        end
        for (int i = 0; i < 4; i++) begin
            send(10'h18B);
            tick();
            checks++;
            if (out_valid !== 1'b1 || data_out !== e[i]) begin
                errors++;
                $display("FAIL rt_out%0d got=%b/%h exp=1/%h", i, out_valid, data_out, e[i]);
            end
        end
        checks++;
        if (gain_cur !== 4'd2 || ramping !== 1'b0) begin
            errors++; $display("FAIL rt_end got=%0d/%b exp=2/0", gain_cur, ramping);
        end
    endtask

    task automatic test_back_to_back();
        int n_out;
        int bad;
        logic [9:0] exp_d;
        n_out = 0;
        bad   = 0;
        for (int c = 0; c < 68; c++) begin
            data_valid = (c < 64);
            data_in    = 10'(385 + c - 32);
            tick();
            if (out_valid === 1'b1) begin
                exp_d = 10'(512 + 2 * (n_out - 32));
                if (n_out != c - 1 || data_out !== exp_d) begin
                    bad++;
                    $display("FAIL stream_s%0d got=%h@%0d exp=%h@%0d", n_out, data_out, c, exp_d, n_out + 1);
                end
                n_out++;
            end
        end
        data_valid = 1'b0;
        checks++;
        if (bad != 0 || n_out != 64) begin
            errors++; $display("FAIL stream got=%0d_pulses/%0d_bad exp=64/0", n_out, bad);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        send(10'd85);
        tick();
        checks++;
        if (clip !== 1'b1 || data_out !== 10'h000) begin
            errors++; $display("FAIL rm_pre got=%b/%h exp=1/000", clip, data_out);
        end
        gain_target = 4'd15;
        tick();
        send(10'h18B);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 10'h200 || gain_cur !== 4'd1 || clip !== 1'b0) begin
            errors++;
            $display("FAIL rm_rst got=%b/%h/%0d/%b exp=0/200/1/0", out_valid, data_out, gain_cur, clip);
        end
        gain_target = 4'd1;
        #3 rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen = seen | out_valid;
        end
        checks++;
        if (seen !== 1'b0 || data_out !== 10'h200 || gain_cur !== 4'd1 || ramping !== 1'b0) begin
            errors++;
            $display("FAIL rm_after got=%b/%h/%0d/%b exp=0/200/1/0", seen, data_out, gain_cur, ramping);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_ramp();
        test_saturate();
        test_gain0();
        test_retarget();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
